// File: rtl/regfile_dualwr_sb.sv
// Dual-write, dual-read register file with optional zero register, optional
// write-to-read bypass and a per-register busy scoreboard for hazard stalls.
module regfile_dualwr_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] addr_r1,
  input  logic [ADDR_W-1:0] addr_r2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              busy_any
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr_a_ok_c;
  logic wr_b_ok_c;
  logic sb_ok_c;

  // Qualify write/set requests; register 0 is read-only when hardwired.
  always_comb begin
    wr_a_ok_c = we_a   && !(ZERO_REG && (waddr_a == '0));
    wr_b_ok_c = we_b   && !(ZERO_REG && (waddr_b == '0));
    sb_ok_c   = sb_set && !(ZERO_REG && (sb_addr == '0));
  end

  // Register array; port B is applied last so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_a_ok_c) begin
        regs_q[waddr_a] <= wdata_a;
      end
      if (wr_b_ok_c) begin
        regs_q[waddr_b] <= wdata_b;
      end
    end
  end

  // Scoreboard next state: retiring writes clear, a new issue sets (set wins).
  always_comb begin
    busy_d = busy_q;
    if (wr_a_ok_c) begin
      busy_d[waddr_a] = 1'b0;
    end
    if (wr_b_ok_c) begin
      busy_d[waddr_b] = 1'b0;
    end
    if (sb_ok_c) begin
      busy_d[sb_addr] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Read port 1: zero register overrides bypass, bypass overrides storage.
  always_comb begin
    read_data1 = regs_q[addr_r1];
    if (BYPASS) begin
      if (wr_b_ok_c && (waddr_b == addr_r1)) begin
        read_data1 = wdata_b;
      end else if (wr_a_ok_c && (waddr_a == addr_r1)) begin
        read_data1 = wdata_a;
      end
    end
    if (ZERO_REG && (addr_r1 == '0)) begin
      read_data1 = '0;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    read_data2 = regs_q[addr_r2];
    if (BYPASS) begin
      if (wr_b_ok_c && (waddr_b == addr_r2)) begin
        read_data2 = wdata_b;
      end else if (wr_a_ok_c && (waddr_a == addr_r2)) begin
        read_data2 = wdata_a;
      end
    end
    if (ZERO_REG && (addr_r2 == '0)) begin
      read_data2 = '0;
    end
  end

  // Busy lookups reflect only the registered scoreboard.
  always_comb begin
    busy1    = busy_q[addr_r1];
    busy2    = busy_q[addr_r2];
    busy_any = |busy_q;
  end

endmodule
